// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier, one step per clock (optional BOOTH_EARLY_EXIT_EN)
module booth_seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state;
    logic [N:0]      acc, m, sum, acc_n;
    logic [N-1:0]    q, q_n;
    logic            q_1, q1_n, last;
    logic [CW-1:0]   count, cnt_n;
    logic [2*N:0]    fin;
    // one Booth step: conditional add/sub followed by arithmetic shift of {A,Q,Q_1}
    always_comb begin
        sum = (q[0] & ~q_1) ? acc - m : (~q[0] & q_1) ? acc + m : acc;
        {acc_n, q_n, q1_n} = $signed({sum, q, q_1}) >>> 1;
        cnt_n = count - 1'b1;
    end
`ifdef BOOTH_EARLY_EXIT_EN
    logic [N-1:0] mask;
    // finish early once every unprocessed multiplier bit equals Q_1: the rest are pure shifts
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) mask[i] = CW'(i) < cnt_n;
        fin = $signed({acc_n, q_n}) >>> cnt_n;
        last = ((q_n ^ {N{q1_n}}) & mask) == '0;
    end
`else
    // fixed latency: exactly N steps
    always_comb begin
        fin = {acc_n, q_n};
        last = cnt_n == '0;
    end
`endif
    // control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc   <= '0;
                    m     <= {a[N-1], a};
                    q     <= b;
                    q_1   <= 1'b0;
                    count <= CW'(N);
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= fin[2*N:N];
                    q     <= fin[N-1:0];
                    q_1   <= q1_n;
                    count <= cnt_n;
                    if (last) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    p     <= {acc[N-1:0], q};
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
